// File: rtl/bist_launcher.sv
// bist_launcher: host-side initiator for the memory BIST start/status/done handshake.
// Build option: define BIST_STOP_ON_FAIL_EN to end a request at the first failing run.
module bist_launcher #(
   parameter int RUNS_W  = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic [RUNS_W-1:0] num_runs,
   output logic              bist_start,
   input  logic              bist_status,
   input  logic              bist_done,
   output logic              busy,
   output logic              result_valid,
   output logic              pass,
   output logic [RUNS_W-1:0] fail_count,
   output logic              timeout_err
);

   typedef enum logic [2:0] {IDLE, START, WAIT, GAP, REPORT} state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic              done_q;
   logic              done_rise;
   logic [15:0]       timer, timer_nxt;
   logic [RUNS_W-1:0] runs_tgt, runs_tgt_nxt;
   logic [RUNS_W-1:0] runs_done, runs_done_nxt;
   logic [RUNS_W-1:0] runs_inc;
   logic [RUNS_W-1:0] fail_inc, fail_nxt;
   logic              busy_nxt, pass_nxt, timeout_nxt;
   logic              run_last, end_req;

   function automatic logic [RUNS_W-1:0] sat_inc(input logic [RUNS_W-1:0] cnt, input logic inc);
      if (&cnt)
         return cnt;
      return cnt + RUNS_W'(inc);
   endfunction

   assign done_rise = bist_done & ~done_q;
   assign runs_inc  = runs_done + RUNS_W'(1);
   assign run_last  = (runs_inc == runs_tgt);
   assign fail_inc  = sat_inc(fail_count, bist_status);

`ifdef BIST_STOP_ON_FAIL_EN
   assign end_req = run_last | bist_status;
`else
   assign end_req = run_last;
`endif

   assign bist_start   = (state == START);
   assign result_valid = (state == REPORT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         done_q      <= 1'b0;
         timer       <= '0;
         runs_tgt    <= '0;
         runs_done   <= '0;
         busy        <= 1'b0;
         pass        <= 1'b0;
         fail_count  <= '0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         done_q      <= bist_done;
         timer       <= timer_nxt;
         runs_tgt    <= runs_tgt_nxt;
         runs_done   <= runs_done_nxt;
         busy        <= busy_nxt;
         pass        <= pass_nxt;
         fail_count  <= fail_nxt;
         timeout_err <= timeout_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      timer_nxt     = timer;
      runs_tgt_nxt  = runs_tgt;
      runs_done_nxt = runs_done;
      busy_nxt      = busy;
      pass_nxt      = pass;
      fail_nxt      = fail_count;
      timeout_nxt   = timeout_err;

      case (state)
         IDLE: begin
            if (req) begin
               runs_tgt_nxt  = (num_runs == '0) ? RUNS_W'(1) : num_runs;
               runs_done_nxt = '0;
               pass_nxt      = 1'b0;
               fail_nxt      = '0;
               timeout_nxt   = 1'b0;
               busy_nxt      = 1'b1;
               state_nxt     = START;
            end
         end
         START: begin
            timer_nxt = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            timer_nxt = timer + 16'd1;
            // A completion on the timeout cycle takes priority over the abort.
            if (done_rise) begin
               fail_nxt      = fail_inc;
               runs_done_nxt = runs_inc;
               if (end_req) begin
                  pass_nxt  = (fail_inc == '0);
                  state_nxt = REPORT;
               end else begin
                  state_nxt = GAP;
               end
            end else if (timer == TIMER_LAST) begin
               timeout_nxt = 1'b1;
               pass_nxt    = 1'b0;
               state_nxt   = REPORT;
            end
         end
         GAP: begin
            state_nxt = START;
         end
         REPORT: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_bist_launcher.sv
// Scoreboard bench for bist_launcher: a reactive BIST model plus a run-level result predictor.
module tb_bist_launcher;

   localparam int RW = 4;
   localparam int TO = 40;
`ifdef BIST_STOP_ON_FAIL_EN
   localparam bit STOP = 1'b1;
`else
   localparam bit STOP = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          req;
   logic [RW-1:0] num_runs;
   logic          bist_start;
   logic          bist_status;
   logic          bist_done;
   logic          busy;
   logic          result_valid;
   logic          pass;
   logic [RW-1:0] fail_count;
   logic          timeout_err;

   // k = cycles from start pulse to done rising (0 = never), hold = cycle a stale done level drops
   typedef struct {int k; int hold; bit st;} run_t;
   typedef struct {bit pass; int fails; bit to; int lat; int starts; int acc;} exp_t;

   run_t plan_q[$];
   run_t cur_runs[$];
   exp_t exp_q[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   bist_launcher #(.RUNS_W(RW), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .num_runs    (num_runs),
      .bist_start  (bist_start),
      .bist_status (bist_status),
      .bist_done   (bist_done),
      .busy        (busy),
      .result_valid(result_valid),
      .pass        (pass),
      .fail_count  (fail_count),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial forever @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic run_t rand_run();
      run_t r;
      int   sel;
      sel = int'($urandom_range(0, 19));
      if (sel == 0)      r.k = 0;
      else if (sel == 1) r.k = TO;
      else if (sel == 2) r.k = 1;
      else               r.k = int'($urandom_range(2, 12));
      r.hold = (r.k == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, r.k - 1));
      r.st   = 1'($urandom);
      return r;
   endfunction

   // Run-level prediction: accept->first start is 1 cycle, each intermediate run costs k+2,
   // the final run k+1, an unanswered run TO+1.
   function automatic exp_t predict(input int num);
      exp_t e;
      int   nr;
      nr       = (num == 0) ? 1 : num;
      e.pass   = 1'b0;
      e.fails  = 0;
      e.to     = 1'b0;
      e.lat    = 1;
      e.starts = 0;
      e.acc    = 0;
      for (int i = 0; i < nr; i++) begin
         e.starts++;
         if (cur_runs[i].k == 0) begin
            e.to   = 1'b1;
            e.lat += TO + 1;
            break;
         end
         if (cur_runs[i].st && e.fails < (1 << RW) - 1) e.fails++;
         if ((STOP && cur_runs[i].st) || i == nr - 1) begin
            e.lat += cur_runs[i].k + 1;
            break;
         end
         e.lat += cur_runs[i].k + 2;
      end
      e.pass = (e.fails == 0) && !e.to;
      return e;
   endfunction

   // Reactive BIST: answers each start pulse with the next planned run
   initial begin : bist_model
      run_t m_run;
      bit   m_act;
      int   m_cyc;
      bist_done   = 1'b0;
      bist_status = 1'b0;
      m_act       = 1'b0;
      m_cyc       = 0;
      m_run       = '{k:0, hold:0, st:1'b0};
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_act       = 1'b0;
            bist_done   = 1'b0;
            bist_status = 1'b0;
         end else begin
            if (bist_start) begin
               chk("start_planned", int'(plan_q.size() > 0), 1);
               if (plan_q.size() > 0) m_run = plan_q.pop_front();
               else                   m_run = '{k:0, hold:0, st:1'b0};
               m_act = 1'b1;
               m_cyc = 0;
            end else if (m_act) begin
               m_cyc++;
            end
            if (m_act) begin
               if (m_cyc == m_run.hold) begin
                  bist_done   = 1'b0;
                  bist_status = 1'($urandom);
               end
               if (m_run.k != 0 && m_cyc == m_run.k) begin
                  bist_done   = 1'b1;
                  bist_status = m_run.st;
                  m_act       = 1'b0;
               end
            end
         end
      end
   end

   initial begin : monitor
      int   starts_seen;
      int   last_start;
      exp_t e;
      starts_seen = 0;
      last_start  = -100;
      forever begin
         @(negedge clk);
         if (!rst) begin
            starts_seen = 0;
            last_start  = -100;
         end else begin
            if (bist_start) begin
               chk("start_spacing", int'(cyc - last_start >= 2), 1);
               starts_seen++;
               last_start = cyc;
            end
            if (result_valid) begin
               chk("result_expected", int'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) begin
                  e = exp_q.pop_front();
                  chk("latency", cyc - e.acc, e.lat);
                  chk("pass", int'(pass), int'(e.pass));
                  chk("fail_count", int'(fail_count), e.fails);
                  chk("timeout_err", int'(timeout_err), int'(e.to));
                  chk("start_pulses", starts_seen, e.starts);
                  chk("busy_at_result", int'(busy), 1);
               end
               starts_seen = 0;
            end
         end
      end
   end

   task automatic check_reset_outputs();
      chk("rst_bist_start", int'(bist_start), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_result_valid", int'(result_valid), 0);
      chk("rst_pass", int'(pass), 0);
      chk("rst_fail_count", int'(fail_count), 0);
      chk("rst_timeout_err", int'(timeout_err), 0);
   endtask

   task automatic reset_dut();
      rst = 1'b0;
      req = 1'b0;
      repeat (2) @(negedge clk);
      plan_q.delete();
      exp_q.delete();
      rst = 1'b1;
   endtask

   task automatic do_request(input int num, input bit junk);
      exp_t e;
      bit   got;
      e      = predict(num);
      plan_q = cur_runs;
      @(negedge clk);
      req      = 1'b1;
      num_runs = RW'(num);
      e.acc    = cyc;
      exp_q.push_back(e);
      got = 1'b0;
      for (int c = 0; c < 16 * (TO + 4) + 20 && !got; c++) begin
         @(negedge clk);
         num_runs = RW'($urandom);
         if (c == 0) chk("busy_after_accept", int'(busy), 1);
         if (result_valid) begin
            got = 1'b1;
            req = 1'b0;
         end else begin
            req = junk ? 1'($urandom) : 1'b0;
         end
      end
      req = 1'b0;
      chk("result_seen", int'(got), 1);
      if (!got) begin
         reset_dut();
      end else begin
         @(negedge clk);
         chk("busy_after_result", int'(busy), 0);
         chk("single_result", int'(result_valid), 0);
      end
      plan_q.delete();
   endtask

   initial begin : stimulus
      int ns;
      int num;
      rst      = 1'b0;
      req      = 1'b0;
      num_runs = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs();
      rst = 1'b1;
      @(negedge clk);

      // single passing run, done 20 cycles after start
      cur_runs.delete();
      cur_runs.push_back('{k:20, hold:0, st:1'b0});
      do_request(1, 1'b0);

      // three runs, statuses 0,1,1
      cur_runs.delete();
      cur_runs.push_back('{k:4, hold:0, st:1'b0});
      cur_runs.push_back('{k:7, hold:2, st:1'b1});
      cur_runs.push_back('{k:5, hold:1, st:1'b1});
      do_request(3, 1'b0);

      // BIST never answers: timeout, second run skipped
      cur_runs.delete();
      cur_runs.push_back('{k:0, hold:0, st:1'b0});
      cur_runs.push_back('{k:5, hold:0, st:1'b0});
      do_request(2, 1'b0);

      // num_runs = 0 runs once; host keeps pulsing req while busy
      cur_runs.delete();
      cur_runs.push_back('{k:6, hold:0, st:1'b0});
      do_request(0, 1'b1);

      // done still high from the previous run, falls at +5, rises at +30
      cur_runs.delete();
      cur_runs.push_back('{k:29, hold:4, st:1'b0});
      do_request(1, 1'b0);

      // reset during run 2 of 4, then a clean 4-run request
      cur_runs.delete();
      for (int i = 0; i < 4; i++) cur_runs.push_back('{k:10, hold:0, st:1'($urandom)});
      plan_q = cur_runs;
      @(negedge clk);
      req      = 1'b1;
      num_runs = RW'(4);
      ns       = 0;
      for (int c = 0; c < 200 && ns < 2; c++) begin
         @(negedge clk);
         req = 1'b0;
         if (bist_start) ns++;
      end
      repeat (3) @(negedge clk);
      chk("abort_in_run2", ns, 2);
      rst = 1'b0;
      #1;
      check_reset_outputs();
      repeat (2) @(negedge clk);
      plan_q.delete();
      exp_q.delete();
      rst = 1'b1;
      cur_runs.delete();
      for (int i = 0; i < 4; i++) cur_runs.push_back('{k:int'($urandom_range(1, 12)), hold:0, st:1'b0});
      do_request(4, 1'b0);

      // randomized requests
      for (int r = 0; r < 25; r++) begin
         num = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 5));
         cur_runs.delete();
         for (int i = 0; i < ((num == 0) ? 1 : num); i++) cur_runs.push_back(rand_run());
         do_request(num, 1'($urandom));
      end

      repeat (2) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
